main_memory_ctrl: RTL and testbench

- Parametrised Harvard main memory for the CPU datapath: separate instruction and data banks behind a single request/done handshake from Control.
- Configurable read/write latency models slow main memory.
- Instruction bank is loaded through a dedicated preload port.
- Out-of-range and illegal accesses are handled deterministically.

---
 rtl/main_memory_ctrl.sv | 144 ++++++++++++++
 tb/tb_main_memory_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl.sv
// Harvard main memory: instruction and data banks behind one req/done handshake
// with a fixed access latency. Define MAIN_MEM_RANGE_CHECK_EN to flag address >= DEPTH with err.
module main_memory_ctrl #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 13,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              write,
    input  logic              instruction,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              done,
    output logic              busy,
    output logic              err,
    input  logic              preload_en,
    input  logic [ADDR_W-1:0] preload_index,
    input  logic [DATA_W-1:0] preload_data
);

    localparam int CNT_W = $clog2(LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              err_q;
    logic              accept;
    logic              exec;
    logic              err_calc;
    logic [DATA_W-1:0] rd_word;

    logic              write_p0;
    logic              instr_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;

    logic [DATA_W-1:0] imem [DEPTH];
    logic [DATA_W-1:0] dmem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    assign accept = req && (state != BUSY);
    assign exec   = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = BUSY;
            BUSY:    if (cnt == '0) next_state = DONE;
            DONE:    next_state = req ? BUSY : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == BUSY);
        done = (state == DONE);
        err  = (state == DONE) && err_q;
    end

    // Request capture stage: live inputs are ignored once the access is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0 <= write;
            instr_p0 <= instruction;
            addr_p0  <= address;
            data_p0  <= dataIn;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if ((state == BUSY) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
`ifdef MAIN_MEM_RANGE_CHECK_EN
        err_calc = (write_p0 && instr_p0) || !in_range(addr_p0);
`else
        err_calc = write_p0 && instr_p0;
`endif
    end

    always_comb begin
        rd_word = '0;
        if (in_range(addr_p0)) begin
            rd_word = instr_p0 ? imem[addr_p0] : dmem[addr_p0];
        end
    end

    // Completion stage: the access takes effect at the edge the counter expires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut <= '0;
            err_q   <= 1'b0;
        end else if (exec) begin
            err_q <= err_calc;
            if (!write_p0) begin
                dataOut <= rd_word;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dmem[i] <= '0;
            end
        end else if (exec && write_p0 && !instr_p0 && in_range(addr_p0)) begin
            dmem[addr_p0] <= data_p0;
        end
    end

    // The instruction bank keeps its contents through reset; reset only blocks preloads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
        end else if (preload_en && in_range(preload_index)) begin
            imem[preload_index] <= preload_data;
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a transaction model.
module tb_main_memory_ctrl;

    localparam int DATA_W = 13;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 13;
    localparam int LAT    = 2;
`ifdef MAIN_MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req = 1'b0;
    logic              write = 1'b0;
    logic              instruction = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] dataIn = '0;
    logic [DATA_W-1:0] dataOut;
    logic              done;
    logic              busy;
    logic              err;
    logic              preload_en = 1'b0;
    logic [ADDR_W-1:0] preload_index = '0;
    logic [DATA_W-1:0] preload_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    main_memory_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .write(write),
        .instruction(instruction), .address(address), .dataIn(dataIn),
        .dataOut(dataOut), .done(done), .busy(busy), .err(err),
        .preload_en(preload_en), .preload_index(preload_index),
        .preload_data(preload_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: arrays for both banks, one pending access with an edge countdown.
    logic [DATA_W-1:0] im [16];
    logic [DATA_W-1:0] dm [16];
    bit                pend = 1'b0;
    int                left = 0;
    bit                m_w, m_i;
    logic [ADDR_W-1:0] m_a;
    logic [DATA_W-1:0] m_d;
    bit                x_done = 1'b0;
    bit                x_err = 1'b0;
    logic [DATA_W-1:0] x_dout = '0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            im[i] = '0;
            dm[i] = '0;
        end
    end

    // Compare what the last edge produced, then advance the model across the next edge.
    always @(negedge clk) begin
        if (!reset) begin
            pend   = 1'b0;
            x_done = 1'b0;
            x_err  = 1'b0;
            x_dout = '0;
            for (int i = 0; i < 16; i++) dm[i] = '0;
        end
        chk("model_done", 32'(done), 32'(x_done));
        chk("model_busy", 32'(busy), 32'(pend));
        chk("model_err", 32'(err), 32'(x_err));
        chk("model_dataOut", 32'(dataOut), 32'(x_dout));
        if (reset) begin
            x_done = 1'b0;
            x_err  = 1'b0;
            if (pend) begin
                left--;
                if (left == 0) begin
                    bit ok;
                    ok = 32'(m_a) < 32'(DEPTH);
                    if (!m_w) x_dout = ok ? (m_i ? im[m_a] : dm[m_a]) : '0;
                    else if (!m_i && ok) dm[m_a] = m_d;
                    x_err  = (m_w && m_i) || (RC && !ok);
                    x_done = 1'b1;
                    pend   = 1'b0;
                end
            end else if (req) begin
                pend = 1'b1;
                left = LAT;
                m_w  = write;
                m_i  = instruction;
                m_a  = address;
                m_d  = dataIn;
            end
            if (preload_en && (32'(preload_index) < 32'(DEPTH))) im[preload_index] = preload_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 20) begin
            step();
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: no done within 20 cycles at %0t", $time);
        end
    endtask

    task automatic access(input bit w, input bit i, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output int k);
        req = 1'b1; write = w; instruction = i; address = a; dataIn = d;
        step();
        req = 1'b0;
        wait_done(k);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nd;
        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_err", 32'(err), 32'(0));
        chk("reset_dataOut", 32'(dataOut), 32'(0));
        reset = 1'b1;
        step();

        for (int i = 0; i < DEPTH; i++) begin
            preload_en = 1'b1;
            preload_index = ADDR_W'(i);
            preload_data = (i == 3) ? 13'h0A5 : (i == 2) ? 13'h011 : DATA_W'($urandom);
            step();
        end
        preload_en = 1'b0;

        // Instruction read with exact timing.
        req = 1'b1; write = 1'b0; instruction = 1'b1; address = 4'd3;
        step();
        req = 1'b0;
        chk("ird_busy0", 32'(busy), 32'(1));
        step();
        chk("ird_busy1", 32'(busy), 32'(1));
        chk("ird_nodone", 32'(done), 32'(0));
        step();
        chk("ird_done", 32'(done), 32'(1));
        chk("ird_busy2", 32'(busy), 32'(0));
        chk("ird_data", 32'(dataOut), 32'h0A5);
        chk("ird_err", 32'(err), 32'(0));
        step();

        // Data write, then back-to-back read issued in the DONE cycle.
        access(1'b1, 1'b0, 4'd5, 13'h1FFF, k);
        chk("dwr_lat", 32'(k), 32'(LAT));
        req = 1'b1; write = 1'b0; instruction = 1'b0; address = 4'd5;
        step();
        req = 1'b0;
        wait_done(k);
        chk("b2b_gap", 32'(k + 1), 32'(LAT + 1));
        chk("b2b_data", 32'(dataOut), 32'h1FFF);

        // Illegal instruction-bank write.
        access(1'b1, 1'b1, 4'd2, 13'h055, k);
        chk("iwr_err", 32'(err), 32'(1));
        chk("iwr_keep", 32'(dataOut), 32'h1FFF);
        access(1'b0, 1'b1, 4'd2, '0, k);
        chk("iwr_intact", 32'(dataOut), 32'h011);
        chk("iwr_rd_err", 32'(err), 32'(0));
        step();

        // Inputs toggling during BUSY must not matter.
        access(1'b1, 1'b0, 4'd4, 13'h123, k);
        step();
        req = 1'b1; write = 1'b0; instruction = 1'b0; address = 4'd4;
        step();
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) begin
                nd++;
                chk("tog_data", 32'(dataOut), 32'h123);
                req = 1'b0; write = 1'b0;
            end else if (busy) begin
                req = 1'($urandom);
                write = 1'($urandom);
                address = ADDR_W'($urandom);
            end else begin
                req = 1'b0;
            end
            step();
        end
        req = 1'b0;
        chk("tog_ndone", 32'(nd), 32'(1));

        // Out-of-range read.
        access(1'b0, 1'b0, 4'd14, '0, k);
        chk("oor_data", 32'(dataOut), 32'(0));
        chk("oor_err", 32'(err), 32'(RC));
        step();

        // Reset in the middle of an access.
        access(1'b1, 1'b0, 4'd1, 13'h007, k);
        step();
        req = 1'b1; write = 1'b0; instruction = 1'b0; address = 4'd1;
        step();
        req = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rst_nodone", 32'(done), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
        end
        reset = 1'b1;
        step();
        access(1'b0, 1'b0, 4'd1, '0, k);
        chk("rst_dclear", 32'(dataOut), 32'(0));
        access(1'b0, 1'b1, 4'd3, '0, k);
        chk("rst_ikeep", 32'(dataOut), 32'h0A5);
        step();

        // Randomized traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            req = 1'($urandom);
            write = ($urandom_range(0, 2) == 0);
            instruction = 1'($urandom);
            address = ADDR_W'($urandom);
            dataIn = DATA_W'($urandom);
            preload_en = ($urandom_range(0, 3) == 0);
            preload_index = ADDR_W'($urandom);
            preload_data = DATA_W'($urandom);
            step();
        end
        reset = 1'b1; req = 1'b0; preload_en = 1'b0;
        repeat (LAT + 3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
